// File: rtl/parameters.sv
// Multi-channel synchronizer with per-channel stability filter and rise/fall pulse outputs.
// Define TESSENT_SYNC_FILTER_EN to build the filter counters and pending flag.
module parameters #(
    parameter int unsigned       WIDTH         = 1,
    parameter int unsigned       STAGES        = 2,
    parameter logic [WIDTH-1:0]  RESET_VALUE   = {WIDTH{1'b0}},
    parameter int unsigned       FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             pending
);

    if (STAGES < 2) begin : g_bad_stages
        $error("parameters: STAGES must be 2 or more");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("parameters: FILTER_CYCLES must be 1 or more");
    end

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // Plain flop chain: no logic between stages.
    always_ff @(posedge clk) begin
        if (!rn) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[STAGES-1];

`ifdef TESSENT_SYNC_FILTER_EN
    localparam int unsigned     CntW   = $clog2(FILTER_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FILTER_CYCLES - 1);

    logic [CntW-1:0] cnt_q [WIDTH];
    logic [CntW-1:0] cnt_d [WIDTH];
    logic            pending_q, pending_d;

    // A channel only follows s after FILTER_CYCLES consecutive differing samples.
    always_comb begin
        q_d       = q_q;
        rise_d    = '0;
        fall_d    = '0;
        pending_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != q_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    q_d[i]    = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            pending_d = pending_d | (|cnt_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rn) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            pending_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
`else
    always_comb begin
        q_d    = s;
        rise_d = s & ~q_q;
        fall_d = ~s & q_q;
    end

    assign pending = 1'b0;
`endif

    // Reset never produces pulses, even when q changes value.
    always_ff @(posedge clk) begin
        if (!rn) begin
            q_q    <= RESET_VALUE;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_parameters.sv
// Scoreboard bench for the filtered synchronizer; expectations follow the
// TESSENT_SYNC_FILTER_EN setting of the build.
module tb_parameters;

    localparam int unsigned W   = 4;
    localparam int unsigned ST  = 2;
    localparam int unsigned FC  = 3;
    localparam logic [3:0]  RV  = 4'b1010;
`ifdef TESSENT_SYNC_FILTER_EN
    localparam int unsigned LAT = ST + FC - 1;
    localparam bit          FILT = 1'b1;
`else
    localparam int unsigned LAT = ST;
    localparam bit          FILT = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] q;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       pending;
    } exp_t;

    logic       clk;
    logic       rn;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       pending;

    int n_run;
    int n_fail;
    exp_t sbq[$];

    parameters #(
        .WIDTH(W),
        .STAGES(ST),
        .RESET_VALUE(RV),
        .FILTER_CYCLES(FC)
    ) dut (
        .clk(clk),
        .rn(rn),
        .d(d),
        .q(q),
        .rise(rise),
        .fall(fall),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [3:0] m_sync [ST];
    logic [3:0] m_q;
    int         m_cnt [4];

    task automatic model_edge(output exp_t e);
        logic [3:0] s;
        e.rise    = '0;
        e.fall    = '0;
        e.pending = 1'b0;
        if (!rn) begin
            for (int k = 0; k < ST; k++) m_sync[k] = RV;
            m_q = RV;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            s = m_sync[ST-1];
            for (int i = 0; i < 4; i++) begin
                if (FILT) begin
                    if (s[i] == m_q[i]) begin
                        m_cnt[i] = 0;
                    end else if (m_cnt[i] == FC - 1) begin
                        m_cnt[i] = 0;
                        m_q[i]   = s[i];
                        if (s[i]) e.rise[i] = 1'b1;
                        else      e.fall[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                    if (m_cnt[i] != 0) e.pending = 1'b1;
                end else if (s[i] != m_q[i]) begin
                    m_q[i] = s[i];
                    if (s[i]) e.rise[i] = 1'b1;
                    else      e.fall[i] = 1'b1;
                end
            end
            for (int k = ST - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
            m_sync[0] = d;
        end
        e.q = m_q;
    endtask

    task automatic test_reset();
        exp_t e;
        rn = 1'b0;
        d  = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                d  = 4'b1010;
                rn = 1'b1;
            end
            model_edge(e);
            sbq.push_back(e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_run++;
            if ({q, rise, fall, pending} !== e) begin
                n_fail++;
                $display("FAIL reset_sb k=%0d got=%b exp=%b", k, {q, rise, fall, pending}, e);
            end
            n_run++;
            if (q !== 4'b1010 || rise !== 4'b0 || fall !== 4'b0 || pending !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state k=%0d got q=%b r=%b f=%b p=%b exp q=1010 r=0 f=0 p=0",
                         k, q, rise, fall, pending);
            end
        end
    endtask

    task automatic test_clean_rise();
        exp_t e;
        d = 4'b1011;
        for (int k = 0; k <= int'(LAT) + 2; k++) begin
            model_edge(e);
            sbq.push_back(e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_run++;
            if ({q, rise, fall, pending} !== e) begin
                n_fail++;
                $display("FAIL rise_sb k=%0d got=%b exp=%b", k, {q, rise, fall, pending}, e);
            end
            n_run++;
            if (rise[0] !== (k == int'(LAT)) || q[0] !== (k >= int'(LAT))
                || pending !== (k >= int'(ST) && k < int'(LAT))) begin
                n_fail++;
                $display("FAIL rise_timing k=%0d got q0=%b r0=%b p=%b exp q0=%b r0=%b p=%b",
                         k, q[0], rise[0], pending, k >= int'(LAT), k == int'(LAT),
                         k >= int'(ST) && k < int'(LAT));
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        // Two-cycle low glitch on d[1]
        for (int k = 0; k <= int'(LAT) + 3; k++) begin
            d = (k < 2) ? 4'b1001 : 4'b1011;
            model_edge(e);
            sbq.push_back(e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_run++;
            if ({q, rise, fall, pending} !== e) begin
                n_fail++;
                $display("FAIL glitch2_sb k=%0d got=%b exp=%b", k, {q, rise, fall, pending}, e);
            end
            n_run++;
            if (fall[1] !== (!FILT && k == int'(ST))
                || q[1] !== (FILT || !(k == int'(ST) || k == int'(ST) + 1))) begin
                n_fail++;
                $display("FAIL glitch2_q1 k=%0d got q1=%b f1=%b", k, q[1], fall[1]);
            end
        end
        n_run++;
        if (pending !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch2_pending_idle got=%b exp=0", pending);
        end
        // One-cycle low glitch on d[3]
        for (int k = 0; k <= int'(LAT) + 3; k++) begin
            d = (k < 1) ? 4'b0011 : 4'b1011;
            model_edge(e);
            sbq.push_back(e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_run++;
            if ({q, rise, fall, pending} !== e) begin
                n_fail++;
                $display("FAIL glitch1_sb k=%0d got=%b exp=%b", k, {q, rise, fall, pending}, e);
            end
            n_run++;
            if (q[3] !== (FILT || k != int'(ST)) || pending !== (FILT && k == int'(ST))) begin
                n_fail++;
                $display("FAIL glitch1_q3 k=%0d got q3=%b p=%b", k, q[3], pending);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        d = 4'b1010;
        for (int k = 0; k <= int'(LAT) + 2; k++) begin
            model_edge(e);
            sbq.push_back(e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_run++;
            if ({q, rise, fall, pending} !== e) begin
                n_fail++;
                $display("FAIL settle_sb k=%0d got=%b exp=%b", k, {q, rise, fall, pending}, e);
            end
        end
        d = 4'b0101;
        for (int k = 0; k <= int'(LAT) + 2; k++) begin
            model_edge(e);
            sbq.push_back(e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_run++;
            if ({q, rise, fall, pending} !== e) begin
                n_fail++;
                $display("FAIL simul_sb k=%0d got=%b exp=%b", k, {q, rise, fall, pending}, e);
            end
            if (k == int'(LAT)) begin
                n_run++;
                if (q !== 4'b0101 || rise !== 4'b0101 || fall !== 4'b1010) begin
                    n_fail++;
                    $display("FAIL simul_edge got q=%b r=%b f=%b exp q=0101 r=0101 f=1010",
                             q, rise, fall);
                end
            end else if (k == int'(LAT) + 1) begin
                n_run++;
                if (rise !== 4'b0 || fall !== 4'b0) begin
                    n_fail++;
                    $display("FAIL simul_once got r=%b f=%b exp r=0000 f=0000", rise, fall);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        d = 4'b0001;
        for (int k = 0; k <= int'(ST) + 2; k++) begin
            rn = (k == int'(ST) + 1) ? 1'b0 : 1'b1;
            model_edge(e);
            sbq.push_back(e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_run++;
            if ({q, rise, fall, pending} !== e) begin
                n_fail++;
                $display("FAIL midrst_sb k=%0d got=%b exp=%b", k, {q, rise, fall, pending}, e);
            end
            if (k == int'(ST) + 1) begin
                n_run++;
                if (q !== RV || rise !== 4'b0 || fall !== 4'b0 || pending !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrst_state got q=%b r=%b f=%b p=%b exp q=1010 r=0 f=0 p=0",
                             q, rise, fall, pending);
                end
            end
        end
        // k=ST+2 above was edge F after release; q must follow at F+LAT.
        for (int k = int'(ST) + 3; k <= int'(ST) + 2 + int'(LAT) + 1; k++) begin
            model_edge(e);
            sbq.push_back(e);
            @(posedge clk); #1;
            e = sbq.pop_front();
            n_run++;
            if ({q, rise, fall, pending} !== e) begin
                n_fail++;
                $display("FAIL relat_sb k=%0d got=%b exp=%b", k, {q, rise, fall, pending}, e);
            end
            n_run++;
            if ((k - int'(ST) - 2) < int'(LAT)) begin
                if (q !== RV) begin
                    n_fail++;
                    $display("FAIL relat_early k=%0d got q=%b exp q=1010", k, q);
                end
            end else if ((k - int'(ST) - 2) == int'(LAT)) begin
                if (q !== 4'b0001 || rise !== 4'b0001 || fall !== 4'b1010) begin
                    n_fail++;
                    $display("FAIL relat_edge got q=%b r=%b f=%b exp q=0001 r=0001 f=1010",
                             q, rise, fall);
                end
            end else if (rise !== 4'b0 || fall !== 4'b0) begin
                n_fail++;
                $display("FAIL relat_after got r=%b f=%b exp r=0000 f=0000", rise, fall);
            end
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rn     = 1'b0;
        d      = 4'b0101;
        @(posedge clk); #1;
        test_reset();
        test_clean_rise();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
